// File: rtl/sdram_pkg.sv
// Shared definitions for the FPGA-to-HPS SDRAM port masters.
package sdram_pkg;
  localparam int F2HSDRAM_DW    = 256;
  localparam int F2HSDRAM_ADDRW = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } writer_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rdata_o always presents the oldest stored word.
module sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap on natural overflow.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sdram_frame_writer.sv
// Avalon-MM burst write master: buffers a pixel stream and writes one frame
// into SDRAM from a programmable word address.
module sdram_frame_writer
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH  = F2HSDRAM_DW,
  parameter int ADDR_WIDTH  = F2HSDRAM_ADDRW,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_WORDS = 194400
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   frame_base_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  output logic [ADDR_WIDTH-1:0]   sdram_address_o,
  output logic [7:0]              sdram_burstcount_o,
  output logic [DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [DATA_WIDTH/8-1:0] sdram_byteenable_o,
  output logic                    sdram_write_o,
  input  logic                    sdram_waitrequest_i
);
  localparam int CW  = $clog2(FRAME_WORDS+1);
  localparam int FCW = $clog2(FIFO_DEPTH+1);

  writer_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [CW-1:0]        written_q, written_d;
  logic [CW-1:0]        accepted_q, accepted_d;
  logic [7:0]           beats_q, beats_d;
  logic [7:0]           bcount_q, bcount_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                  fifo_full, fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push, beat;
  logic [31:0]           rem, blen;

  assign st_ready_o = busy_q && !fifo_full && (32'(accepted_q) < 32'(FRAME_WORDS));
  assign push       = st_ready_o && st_valid_i;
  assign beat       = wr_q && !sdram_waitrequest_i;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .wdata_i (st_data_i),
    .pop_i   (beat),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // written_q only moves after a burst's last beat, so blen is stable per burst.
  always_comb begin
    rem  = 32'(FRAME_WORDS) - 32'(written_q);
    blen = (rem < 32'(BURST_LEN)) ? rem : 32'(BURST_LEN);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_addr_d = out_addr_q;
    written_d  = written_q;
    accepted_d = accepted_q;
    beats_d    = beats_q;
    bcount_d   = bcount_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (push) accepted_d = accepted_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d     = frame_base_i;
          written_d  = '0;
          accepted_d = '0;
          beats_d    = '0;
          busy_d     = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (32'(fifo_count) >= blen) begin
          state_d    = BURST;
          wr_d       = 1'b1;
          out_addr_d = addr_q;
          bcount_d   = 8'(blen);
          beats_d    = 8'(blen);
        end
      end
      BURST: begin
        if (beat) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            wr_d       = 1'b0;
            out_addr_d = '0;
            bcount_d   = '0;
            addr_d     = addr_q + ADDR_WIDTH'(blen);
            written_d  = written_q + CW'(blen);
            if (32'(written_q) + blen == 32'(FRAME_WORDS)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      out_addr_q <= '0;
      written_q  <= '0;
      accepted_q <= '0;
      beats_q    <= '0;
      bcount_q   <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_addr_q <= out_addr_d;
      written_q  <= written_d;
      accepted_q <= accepted_d;
      beats_q    <= beats_d;
      bcount_q   <= bcount_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o             = busy_q;
  assign frame_done_o       = done_q;
  assign sdram_write_o      = wr_q;
  assign sdram_address_o    = out_addr_q;
  assign sdram_burstcount_o = bcount_q;
  assign sdram_byteenable_o = {(DATA_WIDTH/8){wr_q}};
  assign sdram_writedata_o  = wr_q ? fifo_head : '0;
endmodule
